// File: rtl/sr_digit_reader_if.sv
// Signal bundle between the digit reader and whoever feeds it and reads its display outputs.
interface sr_digit_reader_if #(
  parameter int SELW = 3
);
  logic            serial_in;
  logic [SELW-1:0] sel;
  logic            freeze;
  logic [3:0]      digit;
  logic [6:0]      seg;
  logic            digit_valid;
  logic            frame;

  modport master (
    output serial_in, sel, freeze,
    input  digit, seg, digit_valid, frame
  );

  modport slave (
    input  serial_in, sel, freeze,
    output digit, seg, digit_valid, frame
  );
endinterface

// File: rtl/sr_digit_reader.sv
// Tracks bit position in the recirculating hex frame, captures the selected digit
// and drives a registered 7-segment pattern for it.
module sr_digit_reader #(
  parameter int DIGITS = 8,
  parameter int SELW   = 3
) (
  input logic              clk,
  input logic              rst,
  sr_digit_reader_if.slave bus
);
  localparam int LEN = 4 * DIGITS;
  localparam int PW  = $clog2(LEN);

  logic [PW-1:0]   pos_reg, pos_next;
  logic [3:0]      acc_reg, acc_next;
  logic [SELW-1:0] sel_q_reg;
  logic [3:0]      digit_reg;
  logic [6:0]      seg_reg;
  logic            valid_reg;
  logic            frame_reg;
  logic [PW-1:0]   slot;
  logic            capture;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign pos_next = (pos_reg == PW'(LEN - 1)) ? '0 : pos_reg + PW'(1);
  // The last bit of the nibble is still on serial_in, so the completed digit is acc_next.
  assign acc_next = {bus.serial_in, acc_reg[3:1]};
  assign slot     = pos_reg >> 2;
  // Out-of-range sel_q never matches a slot, so no capture happens for it.
  assign capture  = (pos_reg[1:0] == 2'd3) && (slot == PW'(sel_q_reg)) && !bus.freeze;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_reg   <= '0;
      acc_reg   <= '0;
      sel_q_reg <= '0;
      digit_reg <= '0;
      seg_reg   <= 7'h00;
      valid_reg <= 1'b0;
      frame_reg <= 1'b1;
    end else begin
      pos_reg   <= pos_next;
      acc_reg   <= acc_next;
      frame_reg <= (pos_next == '0);
      if (pos_reg == '0)
        sel_q_reg <= bus.sel;
      if (capture) begin
        digit_reg <= acc_next;
        seg_reg   <= seg_decode(acc_next);
        valid_reg <= 1'b1;
      end
    end
  end

  assign bus.digit       = digit_reg;
  assign bus.seg         = seg_reg;
  assign bus.digit_valid = valid_reg;
  assign bus.frame       = frame_reg;
endmodule

// File: doc/sr_digit_reader.md
# sr_digit_reader

Serial-to-digit reader sitting directly downstream of the recirculating hex shift register. It consumes the register's serial output, tracks bit position within the circulating frame, and captures one selected 4-bit hex digit. The captured digit is decoded to a 7-segment pattern for the display outputs. The reader and the shift register share one clock; the reader never stalls the stream.

## Interface

Parameters:
- DIGITS, default 8: hex digits per frame; frame length is 4*DIGITS bits, matching the shift register's LENGTH.
- SELW, default 3: width of digit select; it must equal clog2(DIGITS), minimum 1.

Ports:
- clk  input  1  single clock, shared with the shift register; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- serial_in  input  1  the shift register's data_out.
- sel  input  SELW  index of the digit to display; 0 is the first digit in the frame.
- freeze  input  1  1 holds digit/seg at their current values; capture is suppressed.
- digit  output  4  captured hex digit.
- seg  output  7  registered 7-segment pattern, active-high, bit order {g,f,e,d,c,b,a}.
- digit_valid  output  1  set after the first capture since reset.
- frame  output  1  high for the one cycle in which pos == 0.

## Operation

- Frame format: in each frame, bit position p carries bit (p mod 4) of digit (p div 4), LSB first. pos 0 is the first clock after reset release.
- pos is a counter of width clog2(4*DIGITS). It counts 0..4*DIGITS-1 and wraps to 0. It advances every cycle, and freeze does not stop it.
- acc is a 4-bit accumulator, updated every cycle as acc <= {serial_in, acc[3:1]}.
- sel_q register: sel_q <= sel when pos == 0. A sel change mid-frame takes effect from the next frame, so no torn digit is ever captured.
- sel_q values of DIGITS or above: no capture occurs; outputs hold.
- Capture condition: pos[1:0] == 3, pos div 4 == sel_q, and freeze == 0. On capture: digit <= {serial_in, acc[3:1]}, seg <= decode({serial_in, acc[3:1]}), digit_valid <= 1.
- Decode, 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71 (hex, gfedcba).
- frame is registered and equals (pos_next == 0) before the edge, i.e. it is high exactly when pos == 0.
- freeze asserted across the capture cycle: that frame's capture is lost, and the next capture happens one full frame later.

## Timing

- Reset values: pos = 0, acc = 0, sel_q = 0, digit = 0, seg = 7'h00 (blank), digit_valid = 0, frame = 1 (because pos = 0).
- Reset asserted mid-frame clears all state immediately. pos resynchronises to 0 at release, and the upstream register must be re-framed by system convention.
- Latency: the last bit of digit k is present at serial_in while pos == 4k+3. digit/seg/digit_valid update on that edge, visible while pos == 4k+4 (mod frame).
- Worst-case latency from a sel change to the new digit displayed: 2 frames minus 1 cycle.
- sel is sampled only at pos == 0; a change coincident with that edge uses the new value.
- freeze and capture in the same cycle: freeze wins.

## Test plan

- Reset: assert rst mid-frame with seg = 7F displayed -> seg = 00, digit_valid = 0, frame = 1, all asynchronous to clk.
- Basic capture: DIGITS = 8, stream frame digits 0..7 = 1,2,3,4,5,A,B,F, sel = 5 -> at pos 24 digit = A, seg = 77, digit_valid = 1, and digit stays stable over subsequent identical frames.
- Select change mid-frame: sel changes from 5 to 7 at pos 10 -> digit stays A until the pos-31 capture of the next frame; then digit = F, seg = 71.
- Wrap/last digit: sel = 7 -> capture on the pos-31 edge; frame is high the following cycle; pos wraps to 0 with no extra capture.
- Freeze: freeze = 1 across pos 23 with a new digit 8 in slot 5 -> digit stays A; release freeze, and the next frame captures 8 (seg = 7F).
- Decode sweep: stream each value 0..F in slot 0 on successive frames -> seg follows the full decode table exactly.
